// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave memory bus arbiter with a BUSY watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority (m0 wins).
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_wrdata,
    input  logic [3:0]  m0_byteenable,
    output logic [31:0] m0_rddata,
    output logic        m0_ack,
    output logic        m0_stall,
    output logic        m0_err,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_wrdata,
    input  logic [3:0]  m1_byteenable,
    output logic [31:0] m1_rddata,
    output logic        m1_ack,
    output logic        m1_stall,
    output logic        m1_err,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_address,
    output logic [31:0] s_wrdata,
    output logic [3:0]  s_byteenable,
    input  logic [31:0] s_rddata,
    input  logic        s_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic        owner_q;
    logic [15:0] wdog_q;
    logic        s_read_q;
    logic        s_write_q;
    logic [31:0] s_address_q;
    logic [31:0] s_wrdata_q;
    logic [3:0]  s_be_q;
    logic        m0_ack_q;
    logic        m0_err_q;
    logic [31:0] m0_rddata_q;
    logic        m1_ack_q;
    logic        m1_err_q;
    logic [31:0] m1_rddata_q;

    logic        m0_req;
    logic        m1_req;
    logic        grant1_d;
    logic        sel_rd_d;
    logic        sel_wr_d;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_wdata_d;
    logic [3:0]  sel_be_d;
    logic        done_d;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // On contention the master that was not granted last wins.
    assign grant1_d = m1_req & (~m0_req | ~last_grant_q);
`else
    assign grant1_d = m1_req & ~m0_req;
`endif

    // A master raising both strobes is served as a write.
    always_comb begin
        sel_wr_d    = grant1_d ? m1_write      : m0_write;
        sel_rd_d    = (grant1_d ? m1_read : m0_read) & ~sel_wr_d;
        sel_addr_d  = grant1_d ? m1_address    : m0_address;
        sel_wdata_d = grant1_d ? m1_wrdata     : m0_wrdata;
        sel_be_d    = grant1_d ? m1_byteenable : m0_byteenable;
    end

    assign done_d = s_ack | (wdog_q == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            wdog_q      <= '0;
            s_read_q    <= 1'b0;
            s_write_q   <= 1'b0;
            s_address_q <= '0;
            s_wrdata_q  <= '0;
            s_be_q      <= '0;
            m0_ack_q    <= 1'b0;
            m0_err_q    <= 1'b0;
            m0_rddata_q <= '0;
            m1_ack_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            m1_rddata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        owner_q     <= grant1_d;
                        s_read_q    <= sel_rd_d;
                        s_write_q   <= sel_wr_d;
                        s_address_q <= sel_addr_d;
                        s_wrdata_q  <= sel_wdata_d;
                        s_be_q      <= sel_be_d;
                        wdog_q      <= '0;
                        state_q     <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant1_d;
`endif
                    end
                end
                BUSY: begin
                    if (done_d) begin
                        // A slave ack in the final watchdog cycle still wins.
                        s_read_q  <= 1'b0;
                        s_write_q <= 1'b0;
                        state_q   <= RESP;
                        if (owner_q) begin
                            m1_ack_q    <= 1'b1;
                            m1_err_q    <= ~s_ack;
                            m1_rddata_q <= s_ack ? s_rddata : ERR_DATA;
                        end else begin
                            m0_ack_q    <= 1'b1;
                            m0_err_q    <= ~s_ack;
                            m0_rddata_q <= s_ack ? s_rddata : ERR_DATA;
                        end
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                RESP: begin
                    m0_ack_q <= 1'b0;
                    m0_err_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    m1_err_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_read       = s_read_q;
    assign s_write      = s_write_q;
    assign s_address    = s_address_q;
    assign s_wrdata     = s_wrdata_q;
    assign s_byteenable = s_be_q;

    assign m0_ack    = m0_ack_q;
    assign m0_err    = m0_err_q;
    assign m0_rddata = m0_rddata_q;
    assign m0_stall  = m0_req & ~m0_ack_q;

    assign m1_ack    = m1_ack_q;
    assign m1_err    = m1_err_q;
    assign m1_rddata = m1_rddata_q;
    assign m1_stall  = m1_req & ~m1_ack_q;

endmodule
